// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, hex segment table and select-width helper for seg_scan
package seg_pkg;

    // Segment bit positions inside the 8-bit seg bus
    localparam int SEG_DP_BIT = 7;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_A_BIT  = 0;

    // Active-high g..a patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Width of the binary digit select; never narrower than one bit
    function automatic int sel_w(input int digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// rtl/seg_hex_dec.sv - combinational hex nibble to active-high seven-segment decoder
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    // Straight table lookup; polarity is handled by the caller
    assign segs = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed seven-segment scanner with frame-synchronous data update
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    localparam int SEL_W         = sel_w(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [SEL_W-1:0]      sel,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int               CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(DIGITS - 1);
    localparam logic [7:0]       ALL_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic                frame_done_q, frame_done_d;

    logic                pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_en_q, pend_en_d;
    logic                pend_lz_q, pend_lz_d;

    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   disp_en_q, disp_en_d;
    logic                disp_lz_q, disp_lz_d;

    logic                slot_wrap;
    logic                frame_wrap;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          nib;
    logic                dig_dp;
    logic                dig_en;
    logic                dig_supp;
    logic [6:0]          hex_segs;
    logic [7:0]          seg_ah;

    // Slot timing, digit advance, pending capture and frame-boundary transfer
    always_comb begin
        slot_wrap  = (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (idx_q == IDX_LAST);

        cnt_d = slot_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);
        end

        // Transfer consumes the old pending copy; a load in the same cycle refills it
        pend_valid_d = frame_wrap ? 1'b0 : pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_lz_d    = pend_lz_q;
        if (load) begin
            pend_valid_d = 1'b1;
            pend_data_d  = data_in;
            pend_dp_d    = dp_in;
            pend_en_d    = en_in;
            pend_lz_d    = lz_en;
        end

        disp_data_d = disp_data_q;
        disp_dp_d   = disp_dp_q;
        disp_en_d   = disp_en_q;
        disp_lz_d   = disp_lz_q;
        if (frame_wrap && pend_valid_q) begin
            disp_data_d = pend_data_q;
            disp_dp_d   = pend_dp_q;
            disp_en_d   = pend_en_q;
            disp_lz_d   = pend_lz_q;
        end

        frame_done_d = frame_wrap;
    end

    // Leading-zero mask: a digit is suppressed when it and all higher digits are zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        supp     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_data_d[4*k +: 4] == 4'h0);
            supp[k]  = disp_lz_d && zero_run && (k != 0);
        end
    end

    // Select the next-cycle digit's fields so seg lines up with the registered sel
    always_comb begin
        nib      = 4'h0;
        dig_dp   = 1'b0;
        dig_en   = 1'b0;
        dig_supp = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(idx_d) == k) begin
                nib      = disp_data_d[4*k +: 4];
                dig_dp   = disp_dp_d[k];
                dig_en   = disp_en_d[k];
                dig_supp = supp[k];
            end
        end
    end

    seg_hex_dec u_hex_dec (
        .nibble (nib),
        .segs   (hex_segs)
    );

    // Compose active-high pattern, apply anti-ghost blanking, then output polarity
    always_comb begin
        seg_ah = '0;
        if (dig_en) begin
            seg_ah[SEG_G_BIT:SEG_A_BIT] = dig_supp ? 7'h00 : hex_segs;
            seg_ah[SEG_DP_BIT]          = dig_dp;
        end
        if (int'(cnt_d) < BLANK_CYC) begin
            seg_ah = '0;
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= ALL_OFF;
            frame_done_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_lz_q    <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            disp_lz_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_lz_q    <= pend_lz_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
            disp_lz_q    <= disp_lz_d;
        end
    end

    assign sel        = idx_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - randomized self-checking bench for seg_scan against a frame-level model
module tb_seg_scan;

    localparam int DIG   = 6;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = DIG * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] data_in;
    logic [5:0]  dp_in;
    logic [5:0]  en_in;
    logic        lz_en;
    logic        load;
    logic [2:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Loads seen since the last reset, with the cycle each was presented
    int          q_t[$];
    logic [23:0] q_data[$];
    logic [5:0]  q_dp[$];
    logic [5:0]  q_en[$];
    logic        q_lz[$];

    logic [6:0] hex_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scan #(
        .DIGITS         (DIG),
        .SCAN_DIV       (DIV),
        .BLANK_CYC      (BLANK),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .lz_en      (lz_en),
        .load       (load),
        .sel        (sel),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame f shows the newest load presented before the boundary cycle ending frame f-1
    function automatic int entry_for(int tt);
        int f    = tt / FRAME;
        int best = -1;
        for (int i = 0; i < q_t.size(); i++) begin
            if (q_t[i] < FRAME * f - 1) best = i;
        end
        return best;
    endfunction

    function automatic logic [2:0] exp_sel(int tt);
        return 3'((tt / DIV) % DIG);
    endfunction

    function automatic logic exp_fd(int tt);
        return (tt > 0) && (tt % FRAME == 0);
    endfunction

    function automatic logic [7:0] exp_seg(int tt);
        int          cnt = tt % DIV;
        int          idx = (tt / DIV) % DIG;
        int          e   = entry_for(tt);
        logic [23:0] d;
        logic [23:0] upper;
        logic [3:0]  nib;
        logic [7:0]  ah;
        if (cnt < BLANK) return 8'hFF;
        if (e < 0) return 8'hFF;
        if (!q_en[e][idx]) return 8'hFF;
        d     = q_data[e];
        upper = d >> (4 * idx);
        nib   = upper[3:0];
        ah    = 8'h00;
        ah[7] = q_dp[e][idx];
        if (!(q_lz[e] && idx != 0 && upper == 24'h0)) ah[6:0] = hex_tab[nib];
        return ~ah;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        load = 1'b0;
        t++;
    endtask

    task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] en,
                           input logic lz);
        data_in = d;
        dp_in   = dp;
        en_in   = en;
        lz_en   = lz;
        load    = 1'b1;
        q_t.push_back(t);
        q_data.push_back(d);
        q_dp.push_back(dp);
        q_en.push_back(en);
        q_lz.push_back(lz);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        t   = 0;
        q_t.delete();
        q_data.delete();
        q_dp.delete();
        q_en.delete();
        q_lz.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sel !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d want=0", sel); end
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h want=ff", seg); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd got=%b want=0", frame_done); end
        release_reset();
    endtask

    task automatic test_basic_scan();
        do_load(24'h012345, 6'h00, 6'h3F, 1'b0);
        repeat (2 * FRAME + 4) begin
            checks++; if (sel !== exp_sel(t)) begin failures++; $display("FAIL basic_sel t=%0d got=%0d want=%0d", t, sel, exp_sel(t)); end
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL basic_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            checks++; if (frame_done !== exp_fd(t)) begin failures++; $display("FAIL basic_fd t=%0d got=%b want=%b", t, frame_done, exp_fd(t)); end
            tick();
        end
    endtask

    task automatic test_lz_suppress();
        do_load(24'h00000F, 6'h00, 6'h3F, 1'b1);
        repeat (2 * FRAME) begin
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL lz_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            checks++; if (sel !== exp_sel(t)) begin failures++; $display("FAIL lz_sel t=%0d got=%0d want=%0d", t, sel, exp_sel(t)); end
            tick();
        end
        do_load(24'h000000, 6'b000100, 6'h3F, 1'b1);
        repeat (2 * FRAME) begin
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL lz_zero_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            checks++; if (frame_done !== exp_fd(t)) begin failures++; $display("FAIL lz_zero_fd t=%0d got=%b want=%b", t, frame_done, exp_fd(t)); end
            tick();
        end
    endtask

    task automatic test_last_load_wins();
        while (t % FRAME != 17) tick();
        do_load(24'hABCDEF, 6'h15, 6'h3F, 1'b0);
        tick();
        repeat (9) tick();
        do_load(24'h987654, 6'h2A, 6'h3B, 1'b0);
        repeat (2 * FRAME) begin
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL lastwins_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            checks++; if (frame_done !== exp_fd(t)) begin failures++; $display("FAIL lastwins_fd t=%0d got=%b want=%b", t, frame_done, exp_fd(t)); end
            tick();
        end
    endtask

    task automatic test_load_at_boundary();
        while (t % FRAME != FRAME - 1) tick();
        do_load(24'h5A5A5A, 6'h3F, 6'h3F, 1'b0);
        repeat (2 * FRAME + 2) begin
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL boundary_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            checks++; if (frame_done !== exp_fd(t)) begin failures++; $display("FAIL boundary_fd t=%0d got=%b want=%b", t, frame_done, exp_fd(t)); end
            tick();
        end
    endtask

    task automatic test_async_reset_mid_slot();
        while (!(exp_sel(t) == 3'd3 && t % DIV == 4)) tick();
        rst = 1'b1;
        #1;
        checks++; if (sel !== 3'd0) begin failures++; $display("FAIL async_sel got=%0d want=0", sel); end
        checks++; if (seg !== 8'hFF) begin failures++; $display("FAIL async_seg got=%h want=ff", seg); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL async_fd got=%b want=0", frame_done); end
        release_reset();
        repeat (DIV + 2) begin
            checks++; if (sel !== exp_sel(t)) begin failures++; $display("FAIL post_rst_sel t=%0d got=%0d want=%0d", t, sel, exp_sel(t)); end
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL post_rst_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [23:0] d;
        int          gap;
        repeat (14) begin
            d = 24'($urandom) >> (4 * $urandom_range(0, 6));
            do_load(d, 6'($urandom), 6'($urandom) | 6'h01, 1'($urandom));
            gap = $urandom_range(1, 70);
            repeat (gap) begin
                checks++; if (sel !== exp_sel(t)) begin failures++; $display("FAIL rand_sel t=%0d got=%0d want=%0d", t, sel, exp_sel(t)); end
                checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL rand_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
                checks++; if (frame_done !== exp_fd(t)) begin failures++; $display("FAIL rand_fd t=%0d got=%b want=%b", t, frame_done, exp_fd(t)); end
                tick();
            end
        end
        repeat (3 * FRAME) begin
            checks++; if (sel !== exp_sel(t)) begin failures++; $display("FAIL tail_sel t=%0d got=%0d want=%0d", t, sel, exp_sel(t)); end
            checks++; if (seg !== exp_seg(t)) begin failures++; $display("FAIL tail_seg t=%0d got=%h want=%h", t, seg, exp_seg(t)); end
            checks++; if (frame_done !== exp_fd(t)) begin failures++; $display("FAIL tail_fd t=%0d got=%b want=%b", t, frame_done, exp_fd(t)); end
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        data_in = '0;
        dp_in   = '0;
        en_in   = '0;
        lz_en   = 1'b0;
        load    = 1'b0;
        test_reset();
        test_basic_scan();
        test_lz_suppress();
        test_last_load_wins();
        test_load_at_boundary();
        test_async_reset_mid_slot();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
